// File: rtl/spc_io.sv
// SPC700 memory/IO responder: steers each SMP bus cycle to ARAM, the IPL boot ROM overlay
// or the $F0-$FF register page, and implements CONTROL, the DSP window, S-CPU ports and timers.
module spc_io (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic [15:0] A_IN,
    input  logic [7:0]  D_IN,
    input  logic        WE_N,
    output logic [7:0]  D_OUT,
    output logic [15:0] ARAM_A,
    output logic [7:0]  ARAM_DO,
    input  logic [7:0]  ARAM_DI,
    output logic        ARAM_WE,
    output logic [6:0]  DSP_A,
    output logic [7:0]  DSP_DO,
    input  logic [7:0]  DSP_DI,
    output logic        DSP_WE,
    input  logic [1:0]  CPU_A,
    input  logic [7:0]  CPU_DI,
    input  logic        CPU_WR,
    output logic [7:0]  CPU_DO
);

    // Standard 64-byte IPL boot image, overlaid on $FFC0-$FFFF for reads while CONTROL[7]=1.
    localparam logic [7:0] IPL_ROM [64] = '{
        8'hCD, 8'hEF, 8'hBD, 8'hE8, 8'h00, 8'hC6, 8'h1D, 8'hD0,
        8'hFC, 8'h8F, 8'hAA, 8'hF4, 8'h8F, 8'hBB, 8'hF5, 8'h78,
        8'hCC, 8'hF4, 8'hD0, 8'hFB, 8'h2F, 8'h19, 8'hEB, 8'hF4,
        8'hD0, 8'hFC, 8'h7E, 8'hF4, 8'hD0, 8'h0B, 8'hE4, 8'hF5,
        8'hCB, 8'hF4, 8'hD7, 8'h00, 8'hFC, 8'hD0, 8'hF3, 8'hAB,
        8'h01, 8'h10, 8'hEF, 8'h7E, 8'hF4, 8'h10, 8'hEB, 8'hBA,
        8'hF6, 8'hDA, 8'h00, 8'hBA, 8'hF4, 8'hC4, 8'hF4, 8'hDD,
        8'h5D, 8'hD0, 8'hDB, 8'h1F, 8'h00, 8'h00, 8'hC0, 8'hFF
    };

    logic        io_sel;
    logic [3:0]  reg_idx;
    logic        bus_wr;
    logic        bus_rd;
    logic        io_wr;
    logic        io_rd;

    logic        ipl_en;
    logic [2:0]  timer_en;
    logic [7:0]  dspaddr;
    logic [7:0]  in_latch  [4];
    logic [7:0]  out_latch [4];
    logic [7:0]  target    [3];
    logic [7:0]  stage     [3];
    logic [7:0]  stage_nxt [3];
    logic [3:0]  cnt       [3];
    logic [3:0]  cnt_nxt   [3];
    logic [6:0]  presc;
    logic [2:0]  tick;
    logic [2:0]  inc;

    // CE is a one-CLK strobe per SMP cycle; a bus access commits only on a CLK where CE=1,
    // and A_IN/D_IN/WE_N are held stable by the SMP for the whole cycle leading up to it.
    assign io_sel  = (A_IN[15:4] == 12'h00F);
    assign reg_idx = A_IN[3:0];
    assign bus_wr  = RST_N & CE & ~WE_N;
    assign bus_rd  = RST_N & CE & WE_N;
    assign io_wr   = bus_wr & io_sel;
    assign io_rd   = bus_rd & io_sel;

    // T0/T1 tick on every 128th CE, T2 on every 16th, both from one free-running CE count.
    assign tick = {CE & (presc[3:0] == 4'hF), {2{CE & (presc == 7'h7F)}}};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            inc[i]       = 1'b0;
            stage_nxt[i] = stage[i];
            cnt_nxt[i]   = cnt[i];
            // Target 0 falls out naturally: the 8-bit stage wraps to 0 after 256 ticks.
            if (tick[i] && timer_en[i]) begin
                if (stage[i] + 8'd1 == target[i]) begin
                    stage_nxt[i] = 8'h00;
                    inc[i]       = 1'b1;
                end else begin
                    stage_nxt[i] = stage[i] + 8'd1;
                end
            end
            if (io_rd && reg_idx == 4'(13 + i)) begin
                cnt_nxt[i] = {3'b000, inc[i]};
            end else begin
                cnt_nxt[i] = cnt[i] + {3'b000, inc[i]};
            end
            if (io_wr && reg_idx == 4'h1 && D_IN[i] && !timer_en[i]) begin
                stage_nxt[i] = 8'h00;
                cnt_nxt[i]   = 4'h0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ipl_en   <= 1'b1;
            timer_en <= 3'b000;
            dspaddr  <= 8'h00;
            presc    <= 7'h00;
            for (int i = 0; i < 4; i++) begin
                in_latch[i]  <= 8'h00;
                out_latch[i] <= 8'h00;
            end
            for (int i = 0; i < 3; i++) begin
                target[i] <= 8'h00;
                stage[i]  <= 8'h00;
                cnt[i]    <= 4'h0;
            end
        end else begin
            if (CE) begin
                presc <= presc + 7'd1;
            end
            for (int i = 0; i < 3; i++) begin
                stage[i] <= stage_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            if (io_wr) begin
                case (reg_idx)
                    4'h1: begin
                        timer_en <= D_IN[2:0];
                        ipl_en   <= D_IN[7];
                        if (D_IN[4]) begin
                            in_latch[0] <= 8'h00;
                            in_latch[1] <= 8'h00;
                        end
                        if (D_IN[5]) begin
                            in_latch[2] <= 8'h00;
                            in_latch[3] <= 8'h00;
                        end
                    end
                    4'h2:                   dspaddr                <= D_IN;
                    4'h4, 4'h5, 4'h6, 4'h7: out_latch[reg_idx[1:0]] <= D_IN;
                    4'hA:                   target[0]              <= D_IN;
                    4'hB:                   target[1]              <= D_IN;
                    4'hC:                   target[2]              <= D_IN;
                    default: ;
                endcase
            end
            // Placed after the CONTROL clears so a same-CLK S-CPU write wins for its port.
            if (CPU_WR) begin
                in_latch[CPU_A] <= CPU_DI;
            end
        end
    end

    always_comb begin
        D_OUT = ARAM_DI;
        if (io_sel) begin
            case (reg_idx)
                4'h2:                   D_OUT = dspaddr;
                4'h3:                   D_OUT = DSP_DI;
                4'h4, 4'h5, 4'h6, 4'h7: D_OUT = in_latch[reg_idx[1:0]];
                4'h8, 4'h9:             D_OUT = ARAM_DI;
                4'hD:                   D_OUT = {4'h0, cnt[0]};
                4'hE:                   D_OUT = {4'h0, cnt[1]};
                4'hF:                   D_OUT = {4'h0, cnt[2]};
                default:                D_OUT = 8'h00;
            endcase
        end else if (ipl_en && A_IN[15:6] == 10'h3FF) begin
            D_OUT = IPL_ROM[A_IN[5:0]];
        end
    end

    assign ARAM_A  = A_IN;
    assign ARAM_DO = D_IN;
    assign ARAM_WE = bus_wr;
    assign DSP_A   = dspaddr[6:0];
    assign DSP_DO  = D_IN;
    assign DSP_WE  = io_wr & (reg_idx == 4'h3);
    assign CPU_DO  = out_latch[CPU_A];

endmodule
